// File: rtl/memacc_pkg.sv
// Shared types and helpers for the load-return queue: access-size and
// FSM state encodings, the alignment check and the lane extract/extend.
package memacc_pkg;

  typedef enum logic [1:0] {
    SCOPE_BYTE  = 2'b00,
    SCOPE_HALF  = 2'b01,
    SCOPE_WORD  = 2'b10,
    SCOPE_DWORD = 2'b11
  } scope_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_MISS = 2'b10
  } state_e;

  // True when the access cannot be served from one aligned lane
  // (dword is also illegal on a 32-bit line).
  function automatic logic is_misaligned(input logic [1:0] scope,
                                         input logic [2:0] lsb,
                                         input int         xlen);
    logic bad;
    case (scope)
      SCOPE_BYTE:  bad = 1'b0;
      SCOPE_HALF:  bad = lsb[0];
      SCOPE_WORD:  bad = (lsb[1:0] != 2'b00);
      SCOPE_DWORD: bad = (lsb != 3'b000) || (xlen == 32);
      default:     bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Pick the addressed lane out of a memory line and sign/zero extend it.
  // Big-endian puts byte 0 at the top of the line, so the field's low bit
  // sits at xlen - 8*lsb - width; little-endian puts it at 8*lsb.
  function automatic logic [63:0] lane_extend(input logic [63:0] line,
                                              input int          xlen,
                                              input logic        big_endian,
                                              input logic [1:0]  scope,
                                              input logic        sgn,
                                              input logic [2:0]  lsb);
    logic [6:0]  width_bits;
    logic [6:0]  lo;
    logic [63:0] shifted;
    logic [63:0] res;
    case (scope)
      SCOPE_BYTE:  width_bits = 7'd8;
      SCOPE_HALF:  width_bits = 7'd16;
      SCOPE_WORD:  width_bits = 7'd32;
      SCOPE_DWORD: width_bits = 7'd64;
      default:     width_bits = 7'd8;
    endcase
    if (big_endian) begin
      lo = 7'(xlen) - {1'b0, lsb, 3'b000} - width_bits;
    end else begin
      lo = {1'b0, lsb, 3'b000};
    end
    shifted = line >> lo;
    case (scope)
      SCOPE_BYTE:  res = {{56{sgn & shifted[7]}},  shifted[7:0]};
      SCOPE_HALF:  res = {{48{sgn & shifted[15]}}, shifted[15:0]};
      SCOPE_WORD:  res = {{32{sgn & shifted[31]}}, shifted[31:0]};
      SCOPE_DWORD: res = shifted;
      default:     res = 64'd0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/memacc_rx_q_if.sv
// Handshake bundle between the load pipeline / memory side and the queue.
interface memacc_rx_q_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  localparam int AW = $clog2(XLEN / 8);

  logic             flush_i;
  logic             req_valid_i;
  logic             req_ready_o;
  logic [1:0]       req_scope_i;
  logic             req_signed_i;
  logic [AW-1:0]    req_lsb_i;
  logic [TAG_W-1:0] req_tag_i;
  logic             rsp_valid_i;
  logic             rsp_ready_o;
  logic [XLEN-1:0]  rsp_data_i;
  logic             rsp_miss_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [XLEN-1:0]  out_data_o;
  logic [TAG_W-1:0] out_tag_o;
  logic             out_err_o;
  logic             stall_req_o;

  modport slave (
    input  flush_i, req_valid_i, req_scope_i, req_signed_i, req_lsb_i, req_tag_i,
           rsp_valid_i, rsp_data_i, rsp_miss_i, out_ready_i,
    output req_ready_o, rsp_ready_o, out_valid_o, out_data_o, out_tag_o,
           out_err_o, stall_req_o
  );

  modport master (
    output flush_i, req_valid_i, req_scope_i, req_signed_i, req_lsb_i, req_tag_i,
           rsp_valid_i, rsp_data_i, rsp_miss_i, out_ready_i,
    input  req_ready_o, rsp_ready_o, out_valid_o, out_data_o, out_tag_o,
           out_err_o, stall_req_o
  );
endinterface

// File: rtl/memacc_ldq.sv
// Pending-load FIFO. Pointers carry one extra wrap bit so full and empty
// are distinguishable; no bypass from push to pop.
module memacc_ldq #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW   = $clog2(DEPTH);
  localparam int PTRW = PW + 1;

  logic [W-1:0]    mem_r [DEPTH];
  logic [PTRW-1:0] wr_ptr_r;
  logic [PTRW-1:0] rd_ptr_r;
  logic            do_push_s;
  logic            do_pop_s;

  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  // pointer advance; clear empties the queue without touching storage
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr_r <= {PTRW{1'b0}};
      rd_ptr_r <= {PTRW{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PTRW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTRW'(1);
    end
  end

  // entry storage write
  always_ff @(posedge clk) begin
    if (do_push_s && !clr && !rst) mem_r[wr_ptr_r[PW-1:0]] <= din;
  end

  assign count = wr_ptr_r - rd_ptr_r;
  assign empty = (wr_ptr_r == rd_ptr_r);
  assign full  = (wr_ptr_r[PW] != rd_ptr_r[PW]) &&
                 (wr_ptr_r[PW-1:0] == rd_ptr_r[PW-1:0]);
  assign dout  = mem_r[rd_ptr_r[PW-1:0]];
endmodule

// File: rtl/memacc_rx_q.sv
// Load-return queue: holds issued loads, matches in-order memory responses
// to the head, extracts/extends the addressed lane and registers the
// write-back result. Misses hold the head and request a pipeline stall.
module memacc_rx_q
  import memacc_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int DEPTH      = 4,
  parameter int TAG_W      = 5,
  parameter int BIG_ENDIAN = 1,
  parameter int MISS_LIMIT = 15
) (
  input logic          clk,
  input logic          rst,
  memacc_rx_q_if.slave bus
);
  localparam int AW   = $clog2(XLEN / 8);
  localparam int EW   = 2 + 1 + AW + TAG_W;
  localparam int CW   = $clog2(MISS_LIMIT + 1);
  localparam int CNTW = $clog2(DEPTH) + 1;

  logic [EW-1:0]    push_entry_s;
  logic [EW-1:0]    head_entry_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic [CNTW-1:0]  fifo_count_s;
  logic [1:0]       hd_scope_s;
  logic             hd_signed_s;
  logic [AW-1:0]    hd_lsb_s;
  logic [TAG_W-1:0] hd_tag_s;
  logic             hd_bad_s;
  logic             out_free_s;
  logic             push_s;
  logic             rsp_fire_s;
  logic             hit_s;
  logic             miss_s;
  logic             timeout_s;
  logic             err_done_s;
  logic             pop_s;
  logic             drain_s;
  logic [XLEN-1:0]  hit_data_s;

  state_e           state_r;
  logic             stall_r;
  logic [CW-1:0]    miss_cnt_r;
  logic             out_valid_r;
  logic [XLEN-1:0]  out_data_r;
  logic [TAG_W-1:0] out_tag_r;
  logic             out_err_r;

  assign push_entry_s = {bus.req_scope_i, bus.req_signed_i, bus.req_lsb_i, bus.req_tag_i};
  assign {hd_scope_s, hd_signed_s, hd_lsb_s, hd_tag_s} = head_entry_s;

  memacc_ldq #(.DEPTH(DEPTH), .W(EW)) u_ldq (
    .clk   (clk),
    .rst   (rst),
    .clr   (bus.flush_i),
    .push  (push_s),
    .din   (push_entry_s),
    .pop   (pop_s),
    .dout  (head_entry_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // A head can only retire when the result register is free this cycle.
  assign out_free_s      = !out_valid_r || bus.out_ready_i;
  assign hd_bad_s        = is_misaligned(hd_scope_s, 3'(hd_lsb_s), XLEN);
  assign bus.req_ready_o = !fifo_full_s && !bus.flush_i;
  assign bus.rsp_ready_o = !fifo_empty_s && !bus.flush_i && out_free_s && !hd_bad_s;

  assign push_s     = bus.req_valid_i && bus.req_ready_o;
  assign rsp_fire_s = bus.rsp_valid_i && bus.rsp_ready_o;
  assign hit_s      = rsp_fire_s && !bus.rsp_miss_i;
  assign miss_s     = rsp_fire_s && bus.rsp_miss_i;
  assign timeout_s  = miss_s && (miss_cnt_r == CW'(MISS_LIMIT - 1));
  // misaligned/illegal heads retire with an error, never taking a response
  assign err_done_s = !fifo_empty_s && !bus.flush_i && out_free_s && hd_bad_s;
  assign pop_s      = hit_s || timeout_s || err_done_s;
  assign drain_s    = pop_s && !push_s && (fifo_count_s == CNTW'(1));

  assign hit_data_s = XLEN'(lane_extend(64'(bus.rsp_data_i), XLEN, (BIG_ENDIAN != 0),
                                        hd_scope_s, hd_signed_s, 3'(hd_lsb_s)));

  // result register: load on retire, hold while write-back is back-pressured
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {XLEN{1'b0}};
      out_tag_r   <= {TAG_W{1'b0}};
      out_err_r   <= 1'b0;
    end else if (bus.flush_i) begin
      out_valid_r <= 1'b0;
    end else if (pop_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= hit_s ? hit_data_s : {XLEN{1'b0}};
      out_tag_r   <= hd_tag_s;
      out_err_r   <= !hit_s;
    end else if (bus.out_ready_i) begin
      out_valid_r <= 1'b0;
    end
  end

  // consecutive-miss counter for the current head
  always_ff @(posedge clk) begin
    if (rst || bus.flush_i || pop_s) begin
      miss_cnt_r <= {CW{1'b0}};
    end else if (miss_s) begin
      miss_cnt_r <= miss_cnt_r + CW'(1);
    end
  end

  // queue state machine; stall is raised while the head is in a miss
  always_ff @(posedge clk) begin
    if (rst || bus.flush_i) begin
      state_r <= ST_IDLE;
      stall_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (push_s) state_r <= ST_WAIT;
          stall_r <= 1'b0;
        end
        ST_WAIT: begin
          if (pop_s) begin
            state_r <= drain_s ? ST_IDLE : ST_WAIT;
            stall_r <= 1'b0;
          end else if (miss_s) begin
            state_r <= ST_MISS;
            stall_r <= 1'b1;
          end
        end
        ST_MISS: begin
          if (pop_s) begin
            state_r <= drain_s ? ST_IDLE : ST_WAIT;
            stall_r <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          stall_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_valid_o = out_valid_r;
  assign bus.out_data_o  = out_data_r;
  assign bus.out_tag_o   = out_tag_r;
  assign bus.out_err_o   = out_err_r;
  assign bus.stall_req_o = stall_r;
endmodule

// File: doc/memacc_rx_q.md
MEMACC_RX_Q -- requirements
Module: memacc_rx_q

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits; legal values 32 and 64.
REQ-002 SHALL have parameter DEPTH, default 4, pending-load queue entries; power of 2, at least 2.
REQ-003 SHALL have parameter TAG_W, default 5, destination-register tag width.
REQ-004 SHALL have parameter BIG_ENDIAN, default 1; 1 = big-endian lane order, 0 = little-endian.
REQ-005 SHALL have parameter MISS_LIMIT, default 15, consecutive misses on one load before a timeout error.
REQ-006 SHALL have port clk  in  1  clock; all state changes on its rising edge.
REQ-007 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-008 SHALL have port flush_i  in  1  discard all pending loads.
REQ-009 SHALL have ports req_valid_i / req_ready_o  in/out  1/1  load-issue handshake.
REQ-010 SHALL have ports req_scope_i  in  2  access size: 00 byte, 01 half, 10 word, 11 dword.
REQ-011 SHALL have port req_signed_i  in  1  sign-extend the result.
REQ-012 SHALL have port req_lsb_i  in  AW, where AW = log2(XLEN/8)  low address bits.
REQ-013 SHALL have port req_tag_i  in  TAG_W  destination tag.
REQ-014 SHALL have ports rsp_valid_i / rsp_ready_o  in/out  1/1  memory-response handshake.
REQ-015 SHALL have ports rsp_data_i / rsp_miss_i  in  XLEN/1  raw memory line and miss flag.
REQ-016 SHALL have ports out_valid_o / out_ready_i  out/in  1/1  write-back handshake.
REQ-017 SHALL have ports out_data_o / out_tag_o / out_err_o  out  XLEN/TAG_W/1  extended result, tag, error.
REQ-018 SHALL have port stall_req_o  out  1  pipeline stall request.

Function
REQ-019 Loads SHALL be kept in a FIFO of DEPTH entries holding {scope, signed, lsb, tag}.
REQ-020 The FIFO SHALL accept a load on req_valid_i && req_ready_o.
REQ-021 req_ready_o SHALL equal !full && !flush_i.
REQ-022 When the FIFO is full and the head pops in the same cycle, req_ready_o SHALL still be 0; the FIFO does not bypass.
REQ-023 rsp_ready_o SHALL equal !empty && !flush_i && (!out_valid_o || out_ready_i).
REQ-024 A response SHALL always apply to the FIFO head.
REQ-025 A response with rsp_miss_i=1 SHALL leave the head in place and increment the head miss counter.
REQ-026 A response with rsp_miss_i=1 SHALL drive stall_req_o to 1 from the next cycle until the head completes.
REQ-027 A hit SHALL pop the head and register the result into out_* on the next edge, giving 1-cycle latency.
REQ-028 out_* SHALL hold stable while out_valid_o && !out_ready_i.
REQ-029 Lane select SHALL give byte k (k = lsb) at bits [XLEN-1-8k -: 8] when BIG_ENDIAN=1, else at [8k+7 : 8k]; half, word and dword select analogously on aligned lanes.
REQ-030 Extension SHALL replicate the selected MSB when signed=1, else fill with zeros.
REQ-031 scope 11 SHALL pass rsp_data_i unmodified.
REQ-032 Misalignment SHALL mean any of: half with lsb[0]=1; word with lsb[1:0]!=0; dword with lsb!=0; or scope 11 when XLEN=32.
REQ-033 A misaligned or illegal load SHALL complete with out_err_o=1 and out_data_o=0 without consuming a response; rsp_ready_o=0 for that entry.
REQ-034 When the head miss counter reaches MISS_LIMIT, the head SHALL complete with out_err_o=1 and out_data_o=0, and stall_req_o SHALL drop.
REQ-035 The FSM SHALL have states IDLE (empty), WAIT (head outstanding, no miss), MISS (head missed, stall asserted).
REQ-036 FSM transitions SHALL be: IDLE->WAIT on push; WAIT->MISS on miss; MISS->WAIT on completion with non-empty remainder; WAIT/MISS->IDLE on completion leaving the FIFO empty; any state->IDLE on flush.
REQ-037 flush_i SHALL clear the FIFO, the miss counter, out_valid_o and stall_req_o on the next edge.
REQ-038 flush_i SHALL take priority over a simultaneous push, response or output handshake.
REQ-039 The FIFO pointers SHALL wrap modulo DEPTH, with an extra bit to distinguish full from empty.

Reset
REQ-040 On rst=1 at the clock edge, the following SHALL all go to 0: out_valid_o, out_data_o, out_tag_o, out_err_o, stall_req_o, FIFO pointers and miss counter; FSM SHALL go to IDLE.
REQ-041 Reset mid-operation SHALL drop all pending loads without producing output.

Structure
REQ-042 Scope encodings, FSM state encodings and the byte-lane extract/extend function SHALL live in the shared package memacc_pkg.
REQ-043 The FIFO SHALL be the sub-module memacc_ldq, parameterised by DEPTH and entry width.

Verification
REQ-044 XLEN=32, BIG_ENDIAN=1: byte, signed, lsb=01, rsp_data=0x12F45678, hit -> next cycle out_data=0xFFFFFFF4, err=0.
REQ-045 XLEN=64, BIG_ENDIAN=0: half, unsigned, lsb=110, rsp_data=0x8001_0000_0000_0000 -> out_data=0x0000_0000_0000_8001.
REQ-046 Issue 4 loads with DEPTH=4 -> req_ready_o=0; 4 hits with out_ready_i=1 -> tags emerge in issue order and the FSM returns to IDLE.
REQ-047 Two misses then a hit -> stall_req_o=1 for exactly 2 cycles, then the result is valid.
REQ-048 MISS_LIMIT=3 with continuous misses -> err=1, data=0 after the 3rd miss; half load at lsb=01 -> err=1 with no response consumed.
REQ-049 flush_i asserted with 3 pending loads and out_valid_o=1 -> next cycle out_valid_o=0, req_ready_o=1, FSM IDLE.
